// File: rtl/icache_sa_param.sv
// Parametrised blocking set-associative instruction cache with NRU replacement and flush.
// Latency: hit returns data 1 cycle after accept; a miss responds 1 cycle after the last refill beat.
// Backpressure: o_ready drops during a miss, a flush or a halt; the refill request holds until i_mem_req_ready.
module icache_sa_param #(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORD_WIDTH     = 20,
    parameter int SET_BITS       = 4,
    parameter int OFFSET_BITS    = 4,
    parameter int NUM_WAYS       = 4,
    parameter int WORDS_PER_BEAT = 2
) (
    input  logic                                 clk,
    input  logic                                 arst_n,
    input  logic                                 i_halt,
    input  logic                                 i_flush,
    input  logic [ADDR_WIDTH-1:0]                i_addr,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    output logic [WORD_WIDTH-1:0]                o_data,
    output logic                                 o_valid,
    output logic [ADDR_WIDTH-1:0]                o_mem_addr,
    output logic                                 o_mem_req_valid,
    input  logic                                 i_mem_req_ready,
    input  logic [WORD_WIDTH*WORDS_PER_BEAT-1:0] i_mem_data,
    input  logic                                 i_mem_data_valid
);

    localparam int TAG_BITS = ADDR_WIDTH - SET_BITS - OFFSET_BITS;
    localparam int SETS     = 1 << SET_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int BEATS    = WORDS / WORDS_PER_BEAT;
    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        REFILL,
        RESPOND
    } state_t;

    state_t state;

    // Line storage; contents are only meaningful where the valid bit is set.
    logic [TAG_BITS-1:0]   tag_mem  [NUM_WAYS][SETS];
    logic [WORD_WIDTH-1:0] data_mem [NUM_WAYS][SETS][WORDS];
    logic [NUM_WAYS-1:0]   valid_q  [SETS];
    logic [NUM_WAYS-1:0]   use_q    [SETS];

    logic                   flush_pending;
    logic [CNT_BITS-1:0]    beat_cnt;
    logic [TAG_BITS-1:0]    miss_tag;
    logic [SET_BITS-1:0]    miss_set;
    logic [OFFSET_BITS-1:0] miss_off;
    logic [WAY_BITS-1:0]    miss_way;

    logic [TAG_BITS-1:0]    req_tag;
    logic [SET_BITS-1:0]    req_set;
    logic [OFFSET_BITS-1:0] req_off;
    logic [NUM_WAYS-1:0]    hit_vec;
    logic                   hit;
    logic [WAY_BITS-1:0]    hit_way;
    logic [WORD_WIDTH-1:0]  hit_word;
    logic [WAY_BITS-1:0]    victim;
    logic                   victim_found;
    logic                   accept;
    logic                   beat_last;

    assign req_tag   = i_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_set   = i_addr[OFFSET_BITS +: SET_BITS];
    assign req_off   = i_addr[OFFSET_BITS-1:0];
    assign o_ready   = (state == IDLE) & ~i_flush & ~flush_pending & ~i_halt;
    assign accept    = i_valid & o_ready;
    assign beat_last = (beat_cnt == CNT_BITS'(BEATS - 1));

    // Set the touched way's use bit; if that would saturate the set, keep only the touched way.
    function automatic logic [NUM_WAYS-1:0] use_touch(input logic [NUM_WAYS-1:0] cur,
                                                      input logic [WAY_BITS-1:0] way);
        logic [NUM_WAYS-1:0] oh;
        logic [NUM_WAYS-1:0] nxt;
        oh      = '0;
        oh[way] = 1'b1;
        nxt     = cur | oh;
        return (&nxt) ? oh : nxt;
    endfunction

    // Tag compare across all ways of the requested set, and the matching word.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[req_set][w] && (tag_mem[w][req_set] == req_tag);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_BITS'(w);
            end
        end
        hit      = |hit_vec;
        hit_word = data_mem[hit_way][req_set][req_off];
    end

    // Victim choice: lowest invalid way first, otherwise lowest way whose use bit is clear.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !valid_q[req_set][w]) begin
                victim       = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !use_q[req_set][w]) begin
                victim       = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
    end

    // Refill writes land in the victim line; the tag goes in with the final beat.
    always_ff @(posedge clk) begin
        if (state == REFILL && i_mem_data_valid) begin
            for (int i = 0; i < WORDS_PER_BEAT; i++) begin
                data_mem[miss_way][miss_set][OFFSET_BITS'(int'(beat_cnt) * WORDS_PER_BEAT + i)]
                    <= i_mem_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
            if (beat_last) begin
                tag_mem[miss_way][miss_set] <= miss_tag;
            end
        end
    end

    // Control FSM, line state bits and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state           <= IDLE;
            flush_pending   <= 1'b0;
            beat_cnt        <= '0;
            o_valid         <= 1'b0;
            o_data          <= '0;
            o_mem_req_valid <= 1'b0;
            o_mem_addr      <= '0;
            miss_tag        <= '0;
            miss_set        <= '0;
            miss_off        <= '0;
            miss_way        <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                use_q[s]   <= '0;
            end
        end else begin
            // A flush arriving while a miss is in flight is deferred until back in IDLE.
            if (state != IDLE && i_flush) begin
                flush_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!i_halt) begin
                        o_valid <= accept & hit;
                        if (accept & hit) begin
                            o_data <= hit_word;
                        end
                    end
                    if (i_flush || flush_pending) begin
                        flush_pending <= 1'b0;
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            use_q[s]   <= '0;
                        end
                    end else if (accept) begin
                        if (hit) begin
                            use_q[req_set] <= use_touch(use_q[req_set], hit_way);
                        end else begin
                            miss_tag        <= req_tag;
                            miss_set        <= req_set;
                            miss_off        <= req_off;
                            miss_way        <= victim;
                            o_mem_addr      <= {req_tag, req_set, OFFSET_BITS'(0)};
                            o_mem_req_valid <= 1'b1;
                            state           <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (!i_halt) begin
                        o_valid <= 1'b0;
                    end
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        state           <= REFILL;
                    end
                end
                REFILL: begin
                    if (!i_halt) begin
                        o_valid <= 1'b0;
                    end
                    if (i_mem_data_valid) begin
                        if (beat_last) begin
                            beat_cnt          <= '0;
                            valid_q[miss_set] <= valid_q[miss_set] | (NUM_WAYS'(1) << miss_way);
                            use_q[miss_set]   <= use_touch(use_q[miss_set], miss_way);
                            state             <= RESPOND;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_BITS'(1);
                        end
                    end
                end
                RESPOND: begin
                    if (!i_halt) begin
                        o_valid <= 1'b1;
                        o_data  <= data_mem[miss_way][miss_set][miss_off];
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_sa_param.sv
module tb_icache_sa_param;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_halt;
    logic        i_flush;
    logic [15:0] i_addr;
    logic        i_valid;
    logic        o_ready;
    logic [19:0] o_data;
    logic        o_valid;
    logic [15:0] o_mem_addr;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [39:0] i_mem_data;
    logic        i_mem_data_valid;

    icache_sa_param dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_halt           (i_halt),
        .i_flush          (i_flush),
        .i_addr           (i_addr),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .o_mem_addr       (o_mem_addr),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_data       (i_mem_data),
        .i_mem_data_valid (i_mem_data_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Backing instruction memory.
    logic [19:0] mem [0:65535];

    // Reference model: per set, per way valid/tag/use.
    bit          mv [16][4];
    logic [7:0]  mt [16][4];
    bit          mu [16][4];

    typedef struct {
        logic [15:0] addr;
        bit          hit;
        logic [19:0] data;
        int          delay;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic bit model_peek(input logic [15:0] a);
        int s = int'(a[7:4]);
        for (int w = 0; w < 4; w++) begin
            if (mv[s][w] && mt[s][w] == a[15:8]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                mv[s][w] = 1'b0;
                mu[s][w] = 1'b0;
            end
        end
    endtask

    task automatic model_access(input logic [15:0] a);
        int s = int'(a[7:4]);
        int w = -1;
        bit all_used;
        for (int i = 0; i < 4; i++) if (mv[s][i] && mt[s][i] == a[15:8]) w = i;
        if (w < 0) begin
            for (int i = 0; i < 4; i++) if (w < 0 && !mv[s][i]) w = i;
            for (int i = 0; i < 4; i++) if (w < 0 && !mu[s][i]) w = i;
            if (w < 0) w = 0;
            mv[s][w] = 1'b1;
            mt[s][w] = a[15:8];
        end
        mu[s][w] = 1'b1;
        all_used = 1'b1;
        for (int i = 0; i < 4; i++) all_used &= mu[s][i];
        if (all_used) for (int i = 0; i < 4; i++) mu[s][i] = (i == w);
    endtask

    task automatic send_beat(input int idx);
        i_mem_data       = {mem[idx+1], mem[idx]};
        i_mem_data_valid = 1'b1;
        @(negedge clk);
        i_mem_data_valid = 1'b0;
    endtask

    // One fetch, with refill service on a miss. Called with the bench at a negedge.
    task automatic do_read(input logic [15:0] addr, input bit exp_hit, input logic [19:0] exp_data,
                           input int req_delay, input int halt_cycles, input bit flush_mid,
                           input string name);
        int k;
        int base;
        k = 0;
        while (!o_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({name, ".ready"}, 32'(o_ready), 32'd1);
        model_access(addr);
        i_addr  = addr;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        if (exp_hit) begin
            check({name, ".hit_valid"}, 32'(o_valid), 32'd1);
            check({name, ".hit_data"}, 32'(o_data), 32'(exp_data));
            check({name, ".hit_noreq"}, 32'(o_mem_req_valid), 32'd0);
        end else begin
            base = int'({addr[15:4], 4'h0});
            check({name, ".miss_valid"}, 32'(o_valid), 32'd0);
            check({name, ".miss_req"}, 32'(o_mem_req_valid), 32'd1);
            check({name, ".miss_addr"}, 32'(o_mem_addr), 32'(base));
            for (int d = 0; d < req_delay; d++) begin
                @(negedge clk);
                check({name, ".bp_req"}, 32'(o_mem_req_valid), 32'd1);
                check({name, ".bp_addr"}, 32'(o_mem_addr), 32'(base));
            end
            i_mem_req_ready = 1'b1;
            @(negedge clk);
            i_mem_req_ready = 1'b0;
            check({name, ".req_done"}, 32'(o_mem_req_valid), 32'd0);
            for (int b = 0; b < 8; b++) begin
                if (flush_mid && b == 3) i_flush = 1'b1;
                send_beat(base + 2 * b);
                i_flush = 1'b0;
            end
            if (halt_cycles > 0) begin
                i_halt = 1'b1;
                for (int h = 0; h < halt_cycles; h++) begin
                    @(negedge clk);
                    check({name, ".halt_hold"}, 32'(o_valid), 32'd0);
                end
                i_halt = 1'b0;
            end
            k = 0;
            while (!o_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            check({name, ".resp_valid"}, 32'(o_valid), 32'd1);
            check({name, ".resp_data"}, 32'(o_data), 32'(exp_data));
            if (flush_mid) check({name, ".flush_block"}, 32'(o_ready), 32'd0);
            @(negedge clk);
            check({name, ".one_resp"}, 32'(o_valid), 32'd0);
            if (flush_mid) begin
                check({name, ".flush_ready"}, 32'(o_ready), 32'd1);
                model_flush();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        int base;

        for (int i = 0; i < 65536; i++) mem[i] = {4'hA, 16'(i)};
        for (int n = 0; n < 16; n++) mem[16'h1230 + n] = 20'h10000 + 20'(n);
        model_flush();

        tbl[0]  = '{16'h1234, 1'b0, 20'h10004, 5};
        tbl[1]  = '{16'h1235, 1'b1, 20'h10005, 0};
        tbl[2]  = '{16'h1000, 1'b0, 20'hA1000, 0};
        tbl[3]  = '{16'h1100, 1'b0, 20'hA1100, 1};
        tbl[4]  = '{16'h1200, 1'b0, 20'hA1200, 0};
        tbl[5]  = '{16'h1300, 1'b0, 20'hA1300, 2};
        tbl[6]  = '{16'h1005, 1'b1, 20'hA1005, 0};
        tbl[7]  = '{16'h1400, 1'b0, 20'hA1400, 0};
        tbl[8]  = '{16'h1101, 1'b0, 20'hA1101, 0};
        tbl[9]  = '{16'h1007, 1'b1, 20'hA1007, 0};
        tbl[10] = '{16'h1302, 1'b1, 20'hA1302, 0};
        tbl[11] = '{16'h140F, 1'b1, 20'hA140F, 0};

        arst_n = 1'b0; i_halt = 1'b0; i_flush = 1'b0; i_addr = '0; i_valid = 1'b0;
        i_mem_req_ready = 1'b0; i_mem_data = '0; i_mem_data_valid = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst.o_valid", 32'(o_valid), 32'd0);
        check("rst.o_req", 32'(o_mem_req_valid), 32'd0);
        check("rst.o_data", 32'(o_data), 32'd0);
        check("rst.o_mem_addr", 32'(o_mem_addr), 32'd0);
        arst_n = 1'b1;
        #1;
        check("rst.o_ready", 32'(o_ready), 32'd1);
        @(negedge clk);

        // Cold miss, backpressure, replacement.
        for (int i = 0; i < 12; i++) begin
            do_read(tbl[i].addr, tbl[i].hit, tbl[i].data, tbl[i].delay, 0, 1'b0, $sformatf("tbl%0d", i));
        end

        // Streaming hits over the 0x1230 block.
        i_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            i_addr = 16'h1230 + 16'(n);
            model_access(i_addr);
            @(negedge clk);
            check($sformatf("stream%0d.valid", n), 32'(o_valid), 32'd1);
            check($sformatf("stream%0d.data", n), 32'(o_data), 32'h10000 + 32'(n));
            check($sformatf("stream%0d.noreq", n), 32'(o_mem_req_valid), 32'd0);
        end
        i_valid = 1'b0;
        @(negedge clk);

        // Halt while RESPOND is pending.
        do_read(16'h2340, 1'b0, 20'hA2340, 0, 3, 1'b0, "halt");

        // Flush in IDLE, then a previously cached address misses.
        i_flush = 1'b1;
        #1;
        check("flush_idle.ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        model_flush();
        do_read(16'h1235, 1'b0, 20'h10005, 0, 0, 1'b0, "after_flush");

        // Flush during refill.
        do_read(16'h5670, 1'b0, 20'hA5670, 0, 0, 1'b1, "flush_mid");
        do_read(16'h5670, 1'b0, 20'hA5670, 0, 0, 1'b0, "flush_mid_re");

        // Randomized reads against the reference model.
        for (int r = 0; r < 300; r++) begin
            a = {8'h20 + 8'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            do_read(a, model_peek(a), mem[a], int'($urandom_range(0, 2)), 0, 1'b0, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a refill.
        base = 16'h7890;
        i_addr = 16'h7890;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        @(negedge clk);
        i_mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(base + 2 * b);
        arst_n = 1'b0;
        #1;
        check("rst_mid.o_valid", 32'(o_valid), 32'd0);
        check("rst_mid.o_req", 32'(o_mem_req_valid), 32'd0);
        check("rst_mid.o_data", 32'(o_data), 32'd0);
        check("rst_mid.o_mem_addr", 32'(o_mem_addr), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        model_flush();
        for (int b = 3; b < 8; b++) begin
            send_beat(base + 2 * b);
            check("rst_mid.stray_valid", 32'(o_valid), 32'd0);
        end
        check("rst_mid.stray_req", 32'(o_mem_req_valid), 32'd0);
        do_read(16'h7890, 1'b0, 20'hA7890, 0, 0, 1'b0, "rst_mid_re");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
